// File: rtl/usb_crc_serializer.sv
// USB CRC5/CRC16 serializer: payload LSB-first, then the complemented CRC; first beat the cycle after accept,
// bit_out/bit_valid hold while bit_ready=0. Define USB_BITSTUFF_EN to insert a 0 after six consecutive 1s.
module usb_crc_serializer #(
    parameter int MAX_BITS = 64,
    parameter int LEN_W    = 7
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic                mode,
    input  logic [LEN_W-1:0]    len,
    input  logic [MAX_BITS-1:0] data,
    output logic                ready,
    output logic                bit_out,
    output logic                bit_valid,
    input  logic                bit_ready,
    output logic                done
);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC, S_DONE} state_t;

    state_t                state_q;
    logic [MAX_BITS-1:0]   data_q;
    logic                  mode_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      idx_q;
    logic [3:0]            k_q;
    logic [15:0]           crc_q;
    logic                  ready_q;
    logic                  bit_out_q;
    logic                  bit_valid_q;
    logic                  done_q;
`ifdef USB_BITSTUFF_EN
    logic                  stuff_q;
    logic [2:0]            ones_q;
    logic                  real_bit;
`endif

    logic [15:0] crc_d;
    logic        last_pay;
    logic        last_crc;
    logic        next_bit;
    logic        beat;
    logic        beat_real;

    // CRC5 lives in crc[4:0]; the upper bits are kept clear in that mode.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b, input logic m);
        logic        fb;
        logic [15:0] n;
        fb   = (m ? c[15] : c[4]) ^ b;
        n    = {c[14:0], fb};
        n[2] = n[2] ^ fb;
        if (m) n[15]   = n[15] ^ fb;
        else   n[15:5] = '0;
        return n;
    endfunction

    function automatic logic crc_bit(input logic [15:0] c, input logic m, input logic [4:0] k);
        logic [4:0] pos;
        pos = (m ? 5'd15 : 5'd4) - k;
        return |((c >> pos) & 16'd1);
    endfunction

    function automatic logic data_bit(input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] i);
        return |((d >> i) & MAX_BITS'(1));
    endfunction

    always_comb begin
        beat     = bit_valid_q && bit_ready;
        crc_d    = crc_step(crc_q, bit_out_q, mode_q);
        last_pay = (idx_q == len_q - LEN_W'(1));
        last_crc = ({1'b0, k_q} == (mode_q ? 5'd15 : 5'd4));
        next_bit = 1'b0;
        if (state_q == S_PAYLOAD)
            next_bit = last_pay ? ~crc_bit(crc_d, mode_q, 5'd0) : data_bit(data_q, idx_q + LEN_W'(1));
        else
            next_bit = ~crc_bit(crc_q, mode_q, {1'b0, k_q} + 5'd1);
`ifdef USB_BITSTUFF_EN
        beat_real = beat && !stuff_q;
        real_bit  = (state_q == S_PAYLOAD) ? data_bit(data_q, idx_q)
                                           : ~crc_bit(crc_q, mode_q, {1'b0, k_q});
`else
        beat_real = beat;
`endif
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            crc_q       <= 16'hFFFF;
            ready_q     <= 1'b1;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef USB_BITSTUFF_EN
            stuff_q     <= 1'b0;
            ones_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        data_q      <= data;
                        mode_q      <= mode;
                        len_q       <= (len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : len;
                        crc_q       <= 16'hFFFF;
                        idx_q       <= '0;
                        k_q         <= '0;
                        ready_q     <= 1'b0;
                        bit_valid_q <= 1'b1;
`ifdef USB_BITSTUFF_EN
                        stuff_q     <= 1'b0;
                        ones_q      <= '0;
`endif
                        // Empty payload: first CRC bit is ~seed MSB, i.e. 0.
                        if (len == '0) begin
                            state_q   <= S_CRC;
                            bit_out_q <= 1'b0;
                        end else begin
                            state_q   <= S_PAYLOAD;
                            bit_out_q <= data[0];
                        end
                    end
                end
                S_PAYLOAD, S_CRC: begin
                    if (beat_real) begin
                        if (state_q == S_PAYLOAD) begin
                            crc_q     <= crc_d;
                            idx_q     <= idx_q + LEN_W'(1);
                            bit_out_q <= next_bit;
                            if (last_pay) state_q <= S_CRC;
                        end else begin
                            k_q <= k_q + 4'd1;
                            if (last_crc) begin
                                state_q     <= S_DONE;
                                bit_valid_q <= 1'b0;
                                bit_out_q   <= 1'b0;
                                done_q      <= 1'b1;
                            end else begin
                                bit_out_q <= next_bit;
                            end
                        end
`ifdef USB_BITSTUFF_EN
                        ones_q <= bit_out_q ? ones_q + 3'd1 : 3'd0;
                        // Sixth 1 just went out: the position has advanced, but a 0 goes first.
                        if (bit_out_q && ones_q == 3'd5) begin
                            stuff_q     <= 1'b1;
                            bit_out_q   <= 1'b0;
                            bit_valid_q <= 1'b1;
                            done_q      <= 1'b0;
                        end
`endif
                    end
`ifdef USB_BITSTUFF_EN
                    if (beat && stuff_q) begin
                        stuff_q   <= 1'b0;
                        ones_q    <= '0;
                        bit_out_q <= real_bit;
                    end
`endif
                end
                S_DONE: begin
`ifdef USB_BITSTUFF_EN
                    if (stuff_q) begin
                        if (beat) begin
                            stuff_q     <= 1'b0;
                            ones_q      <= '0;
                            bit_valid_q <= 1'b0;
                            bit_out_q   <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
`else
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready     = ready_q;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_usb_crc_serializer.sv
// Bench for usb_crc_serializer: vector table plus hand sequences, serial bits scored against a polynomial-mask model.
module tb_usb_crc_serializer;
    localparam int MAX_BITS = 64;
    localparam int LEN_W    = 7;

    logic                clk = 1'b0;
    logic                rst_b = 1'b0;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic [LEN_W-1:0]    len = '0;
    logic [MAX_BITS-1:0] data = '0;
    logic                bit_ready = 1'b1;
    logic                ready, bit_out, bit_valid, done;

    always #5 clk = ~clk;

    usb_crc_serializer #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mode(mode), .len(len), .data(data),
        .ready(ready), .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready), .done(done)
    );

    typedef struct {
        logic        m;
        int          l;
        logic [63:0] d;
        bit          stall;
        int          beats;
        bit          chk_crc;
        logic [15:0] crc;
        bit          chk_lat;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int beats = 0;
    int stuffs = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    bit stall_en = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_bit = 1'b0;
    bit exp_q[$];
    bit got_q[$];
    vec_t vt[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference CRC in polynomial-mask form; stuffing modelled on the raw stream.
    task automatic build_exp(input logic m, input int l, input logic [63:0] d);
        int          w, ll, run;
        logic [15:0] c, poly, mask;
        bit          fb;
        bit          raw[$];
        w    = m ? 16 : 5;
        poly = m ? 16'h8005 : 16'h0005;
        mask = m ? 16'hFFFF : 16'h001F;
        c    = mask;
        ll   = (l > MAX_BITS) ? MAX_BITS : l;
        for (int i = 0; i < ll; i++) begin
            fb = c[w-1] ^ d[i];
            c  = (c << 1) & mask;
            if (fb) c = c ^ poly;
            raw.push_back(d[i]);
        end
        for (int k = 0; k < w; k++) raw.push_back(~c[w-1-k]);
        stuffs = 0;
        run = 0;
        foreach (raw[i]) begin
            exp_q.push_back(raw[i]);
`ifdef USB_BITSTUFF_EN
            run = raw[i] ? run + 1 : 0;
            if (run == 6) begin
                exp_q.push_back(1'b0);
                stuffs++;
                run = 0;
            end
`endif
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_hold_valid", bit_valid, 1);
                chk("stall_hold_bit", bit_out, prev_bit);
            end
            if (bit_valid && bit_ready) begin
                got_q.push_back(bit_out);
                beats++;
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("bit", bit_out, exp_q.pop_front());
            end
            prev_stall = bit_valid && !bit_ready;
            prev_bit   = bit_out;
            if (done) done_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bit_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, ready, 1);
    endtask

    task automatic run_xfer(input logic m, input int l, input logic [63:0] d, input bit stall,
                            input int exp_beats, input bit chk_crc, input logic [15:0] exp_crc,
                            input bit chk_lat);
        int          c0, lat, w;
        bit          seen;
        logic [15:0] g;
        wait_ready("ready_before_start");
        build_exp(m, l, d);
        beats    = 0;
        got_q.delete();
        stall_en = stall;
        mode     = m;
        len      = LEN_W'(l);
        data     = d;
        start    = 1'b1;
        @(posedge clk); #1;
        c0    = cyc;
        start = 1'b0;
        mode  = ~m;
        len   = LEN_W'($urandom_range(0, 127));
        data  = {$urandom, $urandom};
        chk("valid_after_accept", bit_valid, 1);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 2000) begin
            @(posedge clk); #1;
            lat = cyc - c0;
            if (done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (chk_lat) chk("done_latency", lat, exp_beats + stuffs);
        chk("ready_low_at_done", ready, 0);
        chk("beat_count", beats, exp_beats + stuffs);
        chk("queue_empty", exp_q.size(), 0);
        if (chk_crc) begin
            w = m ? 16 : 5;
            g = '0;
            if (got_q.size() < w) chk("crc_field_len", got_q.size(), w);
            else begin
                for (int k = 0; k < w; k++) g[k] = got_q[got_q.size() - w + k];
                chk("crc_field", g, exp_crc);
            end
        end
        stall_en = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_done", ready, 1);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, dc0;
        bit          seen;
        logic [63:0] d1, d2, d3;

        vt[0] = '{1'b0, 11,  64'h0,                          1'b0, 16, 1'b1, 16'h0002, 1'b1};
        vt[1] = '{1'b1, 0,   64'h0,                          1'b0, 16, 1'b1, 16'h0000, 1'b1};
        vt[2] = '{1'b0, 11,  {$urandom, $urandom} & 64'h7FF, 1'b1, 16, 1'b0, 16'h0,    1'b0};
        vt[3] = '{1'b1, 64,  {$urandom, $urandom},           1'b1, 80, 1'b0, 16'h0,    1'b0};
        vt[4] = '{1'b1, 100, {$urandom, $urandom},           1'b0, 80, 1'b0, 16'h0,    1'b1};
        vt[5] = '{1'b0, 1,   64'h1,                          1'b0, 6,  1'b0, 16'h0,    1'b1};
        vt[6] = '{1'b1, 32,  64'hFFFF_FFFF,                  1'b1, 48, 1'b0, 16'h0,    1'b0};
        vt[7] = '{1'b1, 8,   64'hFF,                         1'b0, 24, 1'b0, 16'h0,    1'b1};

        #12;
        chk("reset_ready", ready, 1);
        chk("reset_valid", bit_valid, 0);
        chk("reset_bit_out", bit_out, 0);
        chk("reset_done", done, 0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++)
            run_xfer(vt[i].m, vt[i].l, vt[i].d, vt[i].stall, vt[i].beats,
                     vt[i].chk_crc, vt[i].crc, vt[i].chk_lat);

`ifdef USB_BITSTUFF_EN
        for (int i = 0; i < 6; i++) chk("stuff_leading_one", got_q[i], 1);
        chk("stuff_zero_after_six", got_q[6], 0);
`endif

        // start held high, dropped, re-pulsed with other data mid-transfer
        wait_ready("held_ready_before");
        d1 = {$urandom, $urandom} & 64'h7FF;
        d2 = {$urandom, $urandom};
        build_exp(1'b0, 11, d1);
        beats = 0;
        dc0   = done_cnt;
        stall_en = 1'b1;
        mode = 1'b0; len = 7'd11; data = d1; start = 1'b1;
        @(posedge clk); #1;
        mode = 1'b1; len = 7'd40; data = d2;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (n == 6) start = 1'b0;
            else if (n == 7) start = 1'b1;
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
            end
        end
        stall_en = 1'b0;
        chk("held_done_seen", seen, 1);
        @(posedge clk); #1;
        chk("held_ready_back", ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("held_no_restart", bit_valid, 0);
        chk("held_one_done", done_cnt - dc0, 1);
        chk("held_queue_empty", exp_q.size(), 0);
        chk("held_beats", beats, 16 + stuffs);

        // asynchronous reset in the middle of a CRC16 len=64 transfer
        wait_ready("rst_ready_before");
        d3 = {$urandom, $urandom};
        build_exp(1'b1, 64, d3);
        beats = 0;
        mode = 1'b1; len = 7'd64; data = d3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (beats < 5 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reached_beat5", beats >= 5, 1);
        mon_en = 1'b0;
        rst_b  = 1'b0;
        #1;
        chk("rst_valid_low", bit_valid, 0);
        chk("rst_ready_high", ready, 1);
        chk("rst_no_done", done, 0);
        exp_q.delete();
        #3;
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        chk("post_rst_ready", ready, 1);
        prev_stall = 1'b0;
        mon_en = 1'b1;
        run_xfer(1'b0, 8, 64'hFF, 1'b0, 13, 1'b0, 16'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/usb_crc_serializer.md
Name: usb_crc_serializer

Overview:
- Parametrised USB CRC generator and serializer: accepts a payload word plus bit length, streams the payload LSB-first, then appends the complemented CRC5 (token) or CRC16 (data) field.
- Sits between the packet assembler and the NRZI/bit-stuff stage; replaces the fixed 11-bit CRC5 path with a selectable-mode, variable-length, back-pressured block.

Parameters:
- MAX_BITS, 64, maximum payload bits per transfer.
- LEN_W, 7, width of len; must satisfy 2^LEN_W > MAX_BITS.

Ports:
- clk  input  1  clock
- rst_b  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- mode  input  1  0=CRC5 (poly x^5+x^2+1), 1=CRC16 (poly x^16+x^15+x^2+1)
- len  input  LEN_W  payload bit count, 0..MAX_BITS
- data  input  MAX_BITS  payload; data[0] is sent first
- ready  output  1  idle and able to accept start
- bit_out  output  1  serial bit, valid when bit_valid=1
- bit_valid  output  1  bit_out holds a bit
- bit_ready  input  1  downstream accepts bit_out this cycle
- done  output  1  one-cycle pulse after the final bit handshake

Behaviour:
- Reset (asynchronous, active-low rst_b; clock clk): state=IDLE, ready=1, bit_valid=0, bit_out=0, done=0, CRC register all ones, counters 0. Asserting rst_b low mid-transfer aborts immediately; no done pulse.
- Handshake: a beat transfers on a rising edge where bit_valid && bit_ready. bit_out and bit_valid hold stable while bit_ready=0.
- States:
  - IDLE: ready=1. When start=1, the block latches data, mode and len=min(len, MAX_BITS), seeds CRC to all ones (W=5 or 16), and moves to PAYLOAD, or to CRC if len=0.
  - PAYLOAD: bit_valid=1, bit_out=data_q[idx]. Each beat updates the LFSR with that bit:
    - next[0] = crc[W-1]^b
    - next[i] = crc[i-1], XORed with next[0] at the polynomial taps (i=2 for CRC5; i=2,15 for CRC16)
    - idx increments. After beat idx=len-1, the state moves to CRC.
  - CRC: CRC register frozen. Beat k (k=0..W-1) sends ~crc[W-1-k]. After beat k=W-1, the state moves to DONE.
  - DONE: one cycle. done=1, bit_valid=0, ready=0, then IDLE.
- start is ignored outside IDLE. Inputs are sampled only on the accept edge; later changes have no effect.
- Latency: accept at edge N; first bit_valid=1 in cycle N+1. With no stalls there are len+W consecutive beats. done is high in the cycle after the last beat. ready returns in the cycle after done.
- len > MAX_BITS is clamped to MAX_BITS. len=0 sends only the CRC field, which is all zeros since ~all-ones = 0.
- mode is held internally, so mode changes during a transfer do not affect it.

Optional Feature:
- USB_BITSTUFF_EN defined: after six consecutive transmitted 1s (payload and CRC bits counted together), the block inserts a stuffed 0 beat.
  - Stuffed bits do not enter the LFSR and do not advance idx or k.
  - The ones-run counter resets on any 0 beat and on the stuffed beat.
  - A stuff due after the final CRC bit is still sent before DONE.
  - Beat count becomes len+W+stuffs.
- USB_BITSTUFF_EN undefined: no stuffing logic is present; output is the raw bit sequence.

Test Plan:
- CRC5, len=11, data=11'h000 (addr 0, endp 0), bit_ready=1 -> 11 zero beats, then CRC field 5'h02 sent LSB-first (0,1,0,0,0); done in cycle N+17.
- CRC16, len=0 -> 16 beats all 0, then done pulse; ready back high 2 cycles after the last beat.
- CRC5, len=11, random data, bit_ready toggled pseudo-randomly -> bit stream identical to the golden bitwise model; bit_out stable during every stall; no beat lost or duplicated.
- start held high during a transfer plus a second start pulse mid-transfer -> ignored; exactly one done; next start accepted only after ready=1.
- rst_b low at beat 5 of a CRC16 len=64 transfer -> bit_valid=0 and ready=1 immediately; a new len=8 data=8'hFF transfer completes correctly from a fresh seed.
- USB_BITSTUFF_EN, CRC16, len=8, data=8'hFF -> a stuffed 0 is inserted after beat 6; the CRC equals the unstuffed case; total beats = 8+16+stuffs.
